// File: rtl/core_pkg.sv
// Shared definitions for the core instruction-word sequencer: field positions,
// idle instruction value and sequencer states.
package core_pkg;

    localparam int INST_W = 40;

    localparam int B_PSUM_BYPASS = 39;
    localparam int B_ACC         = 38;
    localparam int B_CEN_PMEM    = 37;
    localparam int B_WEN_PMEM    = 36;
    localparam int B_A_PMEM_LO   = 27;
    localparam int A_PMEM_W      = 9;
    localparam int B_CEN1        = 26;
    localparam int B_A1_LO       = 18;
    localparam int B_CEN0        = 17;
    localparam int B_WEN0        = 16;
    localparam int B_A0_LO       = 8;
    localparam int A_XMEM_W      = 8;
    localparam int B_OFIFO_RD    = 7;
    localparam int B_IFIFO_WR    = 6;
    localparam int B_IFIFO_RD    = 5;
    localparam int B_L0_RD       = 4;
    localparam int B_L0_WR       = 3;
    localparam int B_MODE        = 2;
    localparam int B_EXECUTE     = 1;
    localparam int B_LOAD        = 0;

    // Every memory disabled (chip enables and write enables high), everything else low.
    localparam logic [INST_W-1:0] INST_RST = 40'h30_0403_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_EXEC,
        S_FLUSH,
        S_GAP,
        S_DRAIN
    } state_t;

    // Array control bits that trail the XMEM read stream.
    typedef struct packed {
        logic mode;
        logic execute;
        logic load;
    } ctrl_t;

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register that lines up load/execute/mode with the data
// arriving from XMEM a few cycles after the read was issued.
module ctrl_delay_line
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  ctrl_t ctrl,
    output ctrl_t ctrl_dly
);

    ctrl_t stage [DEPTH];

    // NOTE: sequential state uses <= so every stage samples the pre-edge value;
    // with = the whole chain would collapse into a single cycle of delay.
    // NOTE: the stages are reset even though this is shift-register storage,
    // because a stale 1 here would fire load/execute on the array after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else begin
            stage[0] <= ctrl;
            for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
    end

    assign ctrl_dly = stage[DEPTH-1];

endmodule

// File: rtl/core_ctrl.sv
// Run sequencer for core: per kernel index loads weights, streams activations,
// flushes, and drains OFIFO psums into consecutive PMEM addresses.
module core_ctrl
    import core_pkg::*;
#(
    parameter int         COL      = 8,
    parameter int         LEN_NIJ  = 64,
    parameter int         LEN_KIJ  = 1,
    parameter logic [7:0] W_BASE   = 8'h80,
    parameter logic [7:0] X_BASE   = 8'h00,
    parameter int         CTRL_DLY = 2,
    parameter int         GAP      = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              l0_ready,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        kij
);

    localparam int TOTAL = LEN_NIJ * LEN_KIJ;
    localparam int CNT_W = 10;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   wr_cnt, wr_cnt_n;
    logic [3:0]         kij_n;
    logic [INST_W-1:0]  inst_n;
    logic               busy_n, done_n;
    logic               issue, wr, read_prev;
    logic [A_XMEM_W-1:0] a0, w_addr, x_addr;
    ctrl_t              ctrl_c, ctrl_q;

    ctrl_delay_line #(.DEPTH(CTRL_DLY)) u_dly (
        .clk      (clk),
        .reset    (reset),
        .ctrl     (ctrl_c),
        .ctrl_dly (ctrl_q)
    );

    assign w_addr    = W_BASE + 8'(kij * COL) + 8'(cnt);
    assign x_addr    = X_BASE + 8'(cnt);
    assign read_prev = !inst[B_CEN0] && inst[B_WEN0];

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        kij_n    = kij;
        wr_cnt_n = wr_cnt;
        busy_n   = busy;
        done_n   = 1'b0;
        issue    = 1'b0;
        a0       = '0;
        ctrl_c   = '0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_LOAD_W;
                    cnt_n    = '0;
                    kij_n    = '0;
                    wr_cnt_n = '0;
                    busy_n   = 1'b1;
                end
            end
            S_LOAD_W: begin
                a0 = w_addr;
                if (l0_ready) begin
                    issue       = 1'b1;
                    ctrl_c.load = 1'b1;
                    if (cnt == CNT_W'(COL - 1)) begin
                        state_n = S_EXEC;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_EXEC: begin
                a0 = x_addr;
                if (l0_ready) begin
                    issue          = 1'b1;
                    ctrl_c.execute = 1'b1;
                    if (cnt == CNT_W'(LEN_NIJ - 1)) begin
                        state_n = S_FLUSH;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                ctrl_c  = '{mode: 1'b1, execute: 1'b1, load: 1'b1};
                state_n = S_GAP;
                cnt_n   = '0;
            end
            S_GAP: begin
                if (cnt == CNT_W'(GAP - 1)) begin
                    cnt_n = '0;
                    if (kij == 4'(LEN_KIJ - 1)) begin
                        state_n = S_DRAIN;
                    end else begin
                        kij_n   = kij + 4'd1;
                        state_n = S_LOAD_W;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (wr_cnt == CNT_W'(TOTAL)) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Psum drain runs alongside the sequencer and stops counting at TOTAL.
        wr = (state != S_IDLE) && ofifo_valid && (wr_cnt != CNT_W'(TOTAL));
        if (wr) wr_cnt_n = wr_cnt + 1'b1;

        inst_n                          = INST_RST;
        inst_n[B_PSUM_BYPASS]           = (state_n != S_IDLE);
        inst_n[B_ACC]                   = 1'b0;
        inst_n[B_CEN1]                  = 1'b1;
        inst_n[B_A1_LO +: A_XMEM_W]     = '0;
        inst_n[B_IFIFO_WR]              = 1'b0;
        inst_n[B_IFIFO_RD]              = 1'b0;
        inst_n[B_CEN0]                  = !issue;
        inst_n[B_WEN0]                  = 1'b1;
        inst_n[B_A0_LO +: A_XMEM_W]     = a0;
        inst_n[B_L0_WR]                 = read_prev;
        inst_n[B_L0_RD]                 = inst[B_L0_WR];
        inst_n[B_MODE]                  = ctrl_q.mode;
        inst_n[B_EXECUTE]               = ctrl_q.execute;
        inst_n[B_LOAD]                  = ctrl_q.load;
        if (wr) begin
            inst_n[B_OFIFO_RD]              = 1'b1;
            inst_n[B_CEN_PMEM]              = 1'b0;
            inst_n[B_WEN_PMEM]              = 1'b0;
            inst_n[B_A_PMEM_LO +: A_PMEM_W] = wr_cnt[A_PMEM_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            kij    <= '0;
            wr_cnt <= '0;
            inst   <= INST_RST;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            kij    <= kij_n;
            wr_cnt <= wr_cnt_n;
            inst   <= inst_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: single-cycle vector table, then scoreboarded full runs
// (stall, drain, start-while-busy, mid-run reset, three kernel indices).
module tb_core_ctrl;
    import core_pkg::*;

    localparam int COL  = 8;
    localparam int NIJ  = 64;
    localparam logic [39:0] RST_W = 40'h30_0403_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start1 = 1'b0, start3 = 1'b0;
    logic        l0_ready = 1'b0, ofifo_valid = 1'b0;
    logic [39:0] inst1, inst3;
    logic        busy1, busy3, done1, done3;
    logic [3:0]  kij1, kij3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_ctrl #(.LEN_KIJ(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .l0_ready(l0_ready),
        .ofifo_valid(ofifo_valid), .inst(inst1), .busy(busy1), .done(done1), .kij(kij1)
    );

    core_ctrl #(.LEN_KIJ(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .l0_ready(l0_ready),
        .ofifo_valid(ofifo_valid), .inst(inst3), .busy(busy3), .done(done3), .kij(kij3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        rdy;
        logic        ov;
        logic [39:0] inst;
        logic        busy;
        logic        done;
        logic [3:0]  kij;
    } vec_t;

    vec_t tbl [10];

    // Full run on one instance; expected XMEM and PMEM streams go through queues.
    task automatic run(input bit big, input int stall_row, input int v_from,
                       input bit chk_done_tm, input int repoke_at, input int budget);
        logic [7:0]  exp_a0 [$];
        logic [8:0]  exp_pm [$];
        logic [3:0]  rd_h, w_h, a_h, fl_h;
        logic [39:0] iw;
        logic        b, d, ov;
        logic [3:0]  k;
        int nk, per, total, nrd, nwr, bub, vp, model_wr, last_wr, stall_left, idx, kk;
        bit finished;
        nk = big ? 3 : 1;
        per = COL + NIJ;
        total = NIJ * nk;
        nrd = 0; nwr = 0; bub = 0; vp = 0; model_wr = 0; last_wr = -10; stall_left = 0;
        rd_h = '0; w_h = '0; a_h = '0; fl_h = '0;
        finished = 1'b0;
        for (int j = 0; j < nk; j++) begin
            for (int i = 0; i < COL; i++) exp_a0.push_back(8'(8'h80 + j * COL + i));
            for (int i = 0; i < NIJ; i++) exp_a0.push_back(8'(i));
        end

        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge clk);
            if (c > 0) begin
                iw = big ? inst3 : inst1;
                b  = big ? busy3 : busy1;
                d  = big ? done3 : done1;
                k  = big ? kij3  : kij1;
                rd_h = {rd_h[2:0], !iw[B_CEN0] && iw[B_WEN0]};
                w_h  = {w_h[2:0], 1'b0};
                a_h  = {a_h[2:0], 1'b0};
                fl_h = {fl_h[2:0], 1'b0};

                check("l0_wr", 64'(iw[B_L0_WR]), 64'(rd_h[1]));
                check("l0_rd", 64'(iw[B_L0_RD]), 64'(rd_h[2]));
                check("load", 64'(iw[B_LOAD]), 64'(w_h[2] | fl_h[3]));
                check("execute", 64'(iw[B_EXECUTE]), 64'(a_h[2] | fl_h[3]));
                check("mode", 64'(iw[B_MODE]), 64'(fl_h[3]));
                check("const_fields", 64'({iw[38], iw[26], iw[25:18], iw[6:5]}), 64'(12'b0100_0000_0000));
                check("psum_bypass", 64'(iw[B_PSUM_BYPASS]), 64'(b));
                check("pmem_ctrl", 64'({iw[B_CEN_PMEM], iw[B_WEN_PMEM]}), iw[B_OFIFO_RD] ? 64'(0) : 64'(3));
                check("busy", 64'(b), d ? 64'(0) : 64'(1));

                if (rd_h[0]) begin
                    if (exp_a0.size() == 0) begin
                        check("read_count", 64'(nrd + 1), 64'(per * nk));
                    end else begin
                        check("a0", 64'(iw[15:8]), 64'(exp_a0.pop_front()));
                    end
                    idx = nrd % per;
                    kk  = nrd / per;
                    check("kij", 64'(k), 64'(kk));
                    if (nrd == 0) check("first_read_cycle", 64'(c), 64'(2));
                    if (idx == 0) bub = 0;
                    if (idx < COL) w_h[0] = 1'b1;
                    else a_h[0] = 1'b1;
                    if (idx == per - 1) begin
                        fl_h[0] = 1'b1;
                        check("bubbles", 64'(bub), (kk == 0 && stall_row > 0) ? 64'(3) : 64'(0));
                    end
                    if (stall_row > 0 && kk == 0 && idx == COL + stall_row - 1) stall_left = 3;
                    nrd++;
                end else if (nrd % per != 0) begin
                    bub++;
                end

                if (iw[B_OFIFO_RD]) begin
                    if (exp_pm.size() == 0) begin
                        check("pmem_write_count", 64'(nwr + 1), 64'(total));
                    end else begin
                        check("a_pmem", 64'(iw[35:27]), 64'(exp_pm.pop_front()));
                    end
                    nwr++;
                    last_wr = c;
                end

                if (d) begin
                    if (chk_done_tm) check("done_after_last_write", 64'(c - last_wr), 64'(1));
                    check("reads_at_done", 64'(nrd), 64'(per * nk));
                    check("writes_at_done", 64'(nwr), 64'(total));
                    check("a0_queue_empty", 64'(exp_a0.size()), 64'(0));
                    finished = 1'b1;
                end
            end

            if (!finished) begin
                if (big) start3 = (c == 0 || c == repoke_at);
                else start1 = (c == 0 || c == repoke_at);
                l0_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                ov = 1'b0;
                if (nrd >= v_from) begin
                    ov = !(vp >= 32 && vp < 37);
                    vp++;
                    if (ov && model_wr < total) begin
                        exp_pm.push_back(9'(model_wr));
                        model_wr++;
                    end
                end
                ofifo_valid = ov;
            end
        end
        check("done_seen", 64'(finished), 64'(1));
        start1 = 1'b0;
        start3 = 1'b0;
        ofifo_valid = 1'b0;
        l0_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_inst", big ? 64'(inst3) : 64'(inst1), 64'(RST_W));
        check("idle_done", big ? 64'(done3) : 64'(done1), 64'(0));
    endtask

    initial begin
        bit found;

        tbl[0] = '{rst_n:1'b0, start:1'b0, rdy:1'b0, ov:1'b0, inst:RST_W,           busy:1'b0, done:1'b0, kij:4'd0};
        tbl[1] = '{rst_n:1'b1, start:1'b0, rdy:1'b0, ov:1'b1, inst:RST_W,           busy:1'b0, done:1'b0, kij:4'd0};
        tbl[2] = '{rst_n:1'b1, start:1'b1, rdy:1'b0, ov:1'b1, inst:40'hB0_0403_0000, busy:1'b1, done:1'b0, kij:4'd0};
        tbl[3] = '{rst_n:1'b1, start:1'b0, rdy:1'b0, ov:1'b0, inst:40'hB0_0403_8000, busy:1'b1, done:1'b0, kij:4'd0};
        tbl[4] = '{rst_n:1'b1, start:1'b0, rdy:1'b1, ov:1'b1, inst:40'h80_0401_8080, busy:1'b1, done:1'b0, kij:4'd0};
        tbl[5] = '{rst_n:1'b1, start:1'b0, rdy:1'b1, ov:1'b0, inst:40'hB0_0401_8108, busy:1'b1, done:1'b0, kij:4'd0};
        tbl[6] = '{rst_n:1'b1, start:1'b0, rdy:1'b0, ov:1'b0, inst:40'hB0_0403_8219, busy:1'b1, done:1'b0, kij:4'd0};
        tbl[7] = '{rst_n:1'b1, start:1'b0, rdy:1'b1, ov:1'b1, inst:40'h80_0C01_8291, busy:1'b1, done:1'b0, kij:4'd0};
        tbl[8] = '{rst_n:1'b1, start:1'b1, rdy:1'b1, ov:1'b0, inst:40'hB0_0401_8308, busy:1'b1, done:1'b0, kij:4'd0};
        tbl[9] = '{rst_n:1'b0, start:1'b0, rdy:1'b1, ov:1'b0, inst:RST_W,           busy:1'b0, done:1'b0, kij:4'd0};

        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            reset       = tbl[r].rst_n;
            start1      = tbl[r].start;
            l0_ready    = tbl[r].rdy;
            ofifo_valid = tbl[r].ov;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_inst", r), 64'(inst1), 64'(tbl[r].inst));
            check($sformatf("vec%0d_busy", r), 64'(busy1), 64'(tbl[r].busy));
            check($sformatf("vec%0d_done", r), 64'(done1), 64'(tbl[r].done));
            check($sformatf("vec%0d_kij", r), 64'(kij1), 64'(tbl[r].kij));
        end

        @(negedge clk);
        start1 = 1'b0;
        ofifo_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single kernel index: stall at activation row 10, gapped drain, stray start in EXEC.
        run(1'b0, 10, 60, 1'b1, 30, 600);

        // Reset while dut3 streams activation row 5 of its second kernel index.
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (kij3 == 4'd1 && !inst3[B_CEN0] && inst3[15:8] == 8'h05) found = 1'b1;
        end
        check("reset_point_reached", 64'(found), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("mid_reset_inst", 64'(inst3), 64'(RST_W));
        check("mid_reset_busy", 64'(busy3), 64'(0));
        check("mid_reset_kij", 64'(kij3), 64'(0));
        repeat (3) begin
            @(negedge clk);
            check("mid_reset_no_done", 64'(done3), 64'(0));
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Three kernel indices with early, oversupplied psums to exercise write saturation.
        run(1'b1, -1, 10, 1'b0, -1, 1500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
